// File: rtl/mem_rw_master.sv
// Command sequencer in front of a byte-wide memory R/W controller: issues a
// request, waits for ack (with timeout), then streams bytes one at a time.
module mem_rw_master #(
  parameter int ADDR_W      = 6,
  parameter int LEN_W       = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_wr,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic [7:0]        i_wdat,
  input  logic              i_wdat_valid,
  output logic              o_wdat_ready,
  output logic [7:0]        o_rdat,
  output logic              o_rdat_valid,
  input  logic              i_rdat_ready,
  output logic              o_busy,
  output logic              o_err,
  output logic              o_wr_req,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_addr,
  output logic [LEN_W-1:0]  o_num_b,
  input  logic              i_ack,
  output logic [7:0]        o_wr_data,
  output logic              o_wr_valid,
  input  logic              i_wr_done,
  input  logic [7:0]        i_rd_data,
  input  logic              i_rd_valid,
  output logic              o_rd_done
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WR_XFER, S_RD_XFER} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  num_b_q, num_b_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              dir_wr_q, dir_wr_d;
  logic              err_q, err_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_valid_q, wr_valid_d;
  logic [7:0]        rdat_q, rdat_d;
  logic              rdat_valid_q, rdat_valid_d;

  logic wr_accept, wr_fire, rd_free, rd_accept;

  // Only one write byte may be in flight; a read byte is accepted when the
  // host-side buffer is empty or being drained in the same cycle.
  assign wr_accept = (state_q == S_WR_XFER) && !wr_valid_q && i_wdat_valid;
  assign wr_fire   = (state_q == S_WR_XFER) && wr_valid_q && i_wr_done;
  assign rd_free   = !rdat_valid_q || i_rdat_ready;
  assign rd_accept = (state_q == S_RD_XFER) && i_rd_valid && rd_free && (cnt_q != num_b_q);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    num_b_d      = num_b_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    dir_wr_d     = dir_wr_q;
    err_d        = 1'b0;
    wr_data_d    = wr_data_q;
    wr_valid_d   = wr_valid_q;
    rdat_d       = rdat_q;
    rdat_valid_d = rdat_valid_q;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          if (i_cmd_len == '0) begin
            err_d = 1'b1;
          end else begin
            addr_d   = i_cmd_addr;
            num_b_d  = i_cmd_len;
            dir_wr_d = i_cmd_wr;
            cnt_d    = '0;
            tmo_d    = '0;
            state_d  = S_REQ;
          end
        end
      end
      S_REQ: begin
        tmo_d = tmo_q + TMO_W'(1);
        // An ack in the timeout cycle still wins.
        if (i_ack) begin
          state_d = dir_wr_q ? S_WR_XFER : S_RD_XFER;
        end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR_XFER: begin
        if (wr_accept) begin
          wr_data_d  = i_wdat;
          wr_valid_d = 1'b1;
        end
        if (wr_fire) begin
          wr_valid_d = 1'b0;
          cnt_d      = cnt_q + LEN_W'(1);
          addr_d     = addr_q + ADDR_W'(1);
          if (cnt_q + LEN_W'(1) == num_b_q) state_d = S_IDLE;
        end
      end
      S_RD_XFER: begin
        if (rdat_valid_q && i_rdat_ready) rdat_valid_d = 1'b0;
        if (rd_accept) begin
          rdat_d       = i_rd_data;
          rdat_valid_d = 1'b1;
          cnt_d        = cnt_q + LEN_W'(1);
          addr_d       = addr_q + ADDR_W'(1);
        end
        if (cnt_q == num_b_q && rd_free) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      num_b_q      <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      dir_wr_q     <= 1'b0;
      err_q        <= 1'b0;
      wr_data_q    <= '0;
      wr_valid_q   <= 1'b0;
      rdat_q       <= '0;
      rdat_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      num_b_q      <= num_b_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      dir_wr_q     <= dir_wr_d;
      err_q        <= err_d;
      wr_data_q    <= wr_data_d;
      wr_valid_q   <= wr_valid_d;
      rdat_q       <= rdat_d;
      rdat_valid_q <= rdat_valid_d;
    end
  end

  assign o_cmd_ready  = (state_q == S_IDLE);
  assign o_busy       = (state_q != S_IDLE);
  assign o_wr_req     = (state_q == S_REQ) && dir_wr_q;
  assign o_rd_req     = (state_q == S_REQ) && !dir_wr_q;
  assign o_wdat_ready = wr_accept;
  assign o_rd_done    = rd_accept;
  assign o_err        = err_q;
  assign o_addr       = addr_q;
  assign o_num_b      = num_b_q;
  assign o_wr_data    = wr_data_q;
  assign o_wr_valid   = wr_valid_q;
  assign o_rdat       = rdat_q;
  assign o_rdat_valid = rdat_valid_q;

endmodule

// File: doc/mem_rw_master.md
Name: mem_rw_master

Overview:
Command sequencer that sits directly upstream of the byte-wide memory R/W controller. It accepts one read or write command at a time from the host, issues the request and byte count, and waits for the acknowledge. It then streams bytes across the controller's valid/done handshakes, advancing the address per byte, and returns read bytes to the host on a valid/ready stream. Ack timeout and zero-length commands are reported as errors.

Parameters:
ADDR_W, 6, memory address width; address wraps modulo 2^ADDR_W.
LEN_W, 4, byte-count width; max burst 2^LEN_W-1 bytes.
ACK_TIMEOUT, 15, cycles to wait for i_ack after request before abort.

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous reset, active-high
i_cmd_valid  in  1  host command valid
o_cmd_ready  out  1  high only in IDLE
i_cmd_wr  in  1  1=write, 0=read
i_cmd_addr  in  ADDR_W  start address
i_cmd_len  in  LEN_W  byte count
i_wdat  in  8  host write byte
i_wdat_valid  in  1  host write byte valid
o_wdat_ready  out  1  write byte accepted this cycle
o_rdat  out  8  read byte to host
o_rdat_valid  out  1  read byte valid, held until i_rdat_ready
i_rdat_ready  in  1  host accepts read byte
o_busy  out  1  not IDLE
o_err  out  1  one-cycle error pulse
o_wr_req  out  1  write request to controller
o_rd_req  out  1  read request to controller
o_addr  out  ADDR_W  current byte address
o_num_b  out  LEN_W  latched byte count
i_ack  in  1  controller acknowledge
o_wr_data  out  8  byte to controller
o_wr_valid  out  1  write byte valid, held until i_wr_done
i_wr_done  in  1  controller wrote byte
i_rd_data  in  8  byte from controller
i_rd_valid  in  1  controller read byte valid
o_rd_done  out  1  one-cycle read-byte accept pulse

Behaviour:
- Reset (async, any state, mid-burst included): state IDLE. All outputs 0, except o_cmd_ready=1. Counters, address and buffers cleared. The in-flight command is dropped silently.
- States: IDLE, REQ, WR_XFER, RD_XFER.
- IDLE: o_cmd_ready=1. On i_cmd_valid:
  - If i_cmd_len==0: o_err pulses next cycle; stay IDLE; no request issued.
  - Otherwise: latch addr, len and direction into o_addr and o_num_b; clear byte count and timeout counter; go to REQ.
- REQ: o_wr_req or o_rd_req held high per direction. The timeout counter increments each cycle.
  - i_ack=1 -> drop req; go to WR_XFER or RD_XFER next cycle.
  - Counter reaches ACK_TIMEOUT without ack -> o_err pulse, req dropped, return to IDLE.
  - Ack arriving in the same cycle as timeout: ack wins.
- WR_XFER:
  - With o_wr_valid=0 and i_wdat_valid=1: o_wdat_ready pulses, byte captured into o_wr_data, o_wr_valid=1 next cycle.
  - o_wr_valid and o_wr_data hold until i_wr_done. On i_wr_done, the same edge clears o_wr_valid, increments the byte count, and increments o_addr (wrap).
  - o_wdat_ready is never high while o_wr_valid=1 (one byte in flight).
  - When count==o_num_b -> IDLE.
- RD_XFER:
  - On i_rd_valid with o_rdat_valid=0: capture i_rd_data into o_rdat, set o_rdat_valid, pulse o_rd_done for 1 cycle, count++, o_addr++ (wrap).
  - If o_rdat_valid=1 and the host has not taken the byte, o_rd_done is withheld (backpressure).
  - If i_rdat_ready arrives in the same cycle as a new i_rd_valid, the new byte is accepted (pass-through, no bubble).
  - When count==o_num_b, go to IDLE once o_rdat_valid clears.
- o_busy = state != IDLE. o_wr_req and o_rd_req are never high together.
- Byte count is LEN_W bits and never exceeds o_num_b; o_addr wraps 2^ADDR_W-1 -> 0.

Test Plan:
- Write addr=0x05 len=3, bytes A1,B2,C3, i_ack after 2 cycles, i_wr_done 1 cycle after each valid -> o_wr_req high for 3 cycles. o_wr_data A1@05, B2@06, C3@07. o_num_b=3. Back to IDLE, o_err=0.
- Read addr=0x3E len=4, i_rdat_ready tied high, controller returns 11,22,33,44 -> o_addr 3E,3F,00,01 (wrap). o_rdat sequence 11,22,33,44. Four o_rd_done pulses.
- Read len=2 with i_rdat_ready low for 5 cycles after first byte -> o_rdat=first byte held. No second o_rd_done until ready. Both bytes delivered in order.
- Command with i_ack never asserted -> req drops after 15 cycles. One o_err pulse. o_cmd_ready=1 afterwards.
- Command len=0 -> o_err pulse, o_wr_req and o_rd_req stay 0, o_busy stays 0.
- Assert i_reset mid-write after 1 of 3 bytes -> all outputs 0 immediately (async), o_cmd_ready=1. A subsequent write len=1 completes normally.
